// File: rtl/pcx_fpga_arb.sv
// Two-core PCX request arbiter in front of a single FPGA bridge target.
// Per-core FIFOs, round-robin service, atomic pairs forwarded back-to-back.
module pcx_fpga_arb #(
  parameter int DEPTH = 10,
  parameter int PTR_W = 4
) (
  input  logic         gclk,
  input  logic         reset_l,
  input  logic [4:0]   c0_pcx_req_pq,
  input  logic         c0_pcx_atom_pq,
  input  logic [123:0] c0_pcx_data_pa,
  output logic [4:0]   c0_pcx_grant_px,
  input  logic [4:0]   c1_pcx_req_pq,
  input  logic         c1_pcx_atom_pq,
  input  logic [123:0] c1_pcx_data_pa,
  output logic [4:0]   c1_pcx_grant_px,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [123:0] out_data,
  output logic [4:0]   out_dest,
  output logic         out_core,
  output logic         out_atom,
  output logic [1:0]   err_ovf,
  output logic [1:0]   err_req
);

  localparam int              EW      = 130;
  localparam logic [PTR_W:0]   LP_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] LP_LAST = PTR_W'(DEPTH - 1);

  logic [4:0]    w_req     [2];
  logic          w_atom_in [2];
  logic [123:0]  w_data_in [2];

  logic [4:0]       r_cap_dest [2];
  logic             r_cap_atom [2];
  logic             r_cap_vld  [2];
  logic [EW-1:0]    r_mem      [2][DEPTH];
  logic [PTR_W-1:0] r_wp       [2];
  logic [PTR_W-1:0] r_rp       [2];
  logic [PTR_W:0]   r_cnt      [2];
  logic [4:0]       r_grant    [2];
  logic             r_rr, r_lock_vld, r_lock_core, r_hold_vld, r_hold_core;
  logic [1:0]       r_err_ovf, r_err_req;

  logic [1:0]    w_ne, w_full, w_pop, w_wr;
  logic          w_sel, w_vld, w_xfer;
  logic [EW-1:0] w_head;

  function automatic logic multi_hot(input logic [4:0] v);
    return (v & (v - 5'd1)) != 5'd0;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LP_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_req[0]     = c0_pcx_req_pq;
  assign w_req[1]     = c1_pcx_req_pq;
  assign w_atom_in[0] = c0_pcx_atom_pq;
  assign w_atom_in[1] = c1_pcx_atom_pq;
  assign w_data_in[0] = c0_pcx_data_pa;
  assign w_data_in[1] = c1_pcx_data_pa;

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      w_ne[c]   = r_cnt[c] != '0;
      w_full[c] = r_cnt[c] == LP_FULL;
    end
  end

  // A held choice keeps out_* stable while the target stalls.
  always_comb begin
    w_sel = 1'b0;
    w_vld = 1'b0;
    if (r_lock_vld) begin
      w_sel = r_lock_core;
      w_vld = w_ne[r_lock_core];
    end else if (r_hold_vld) begin
      w_sel = r_hold_core;
      w_vld = w_ne[r_hold_core];
    end else if (w_ne[0] && w_ne[1]) begin
      w_sel = ~r_rr;
      w_vld = 1'b1;
    end else if (w_ne[0]) begin
      w_sel = 1'b0;
      w_vld = 1'b1;
    end else if (w_ne[1]) begin
      w_sel = 1'b1;
      w_vld = 1'b1;
    end
  end

  assign w_head   = r_mem[w_sel][r_rp[w_sel]];
  assign out_vld  = w_vld;
  assign out_data = w_vld ? w_head[123:0]   : '0;
  assign out_atom = w_vld ? w_head[124]     : 1'b0;
  assign out_dest = w_vld ? w_head[129:125] : 5'd0;
  assign out_core = w_vld & w_sel;
  assign w_xfer   = w_vld & out_rdy;

  // A full FIFO still accepts a write when its head leaves in the same cycle.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      w_pop[c] = w_xfer && (w_sel == c[0]);
      w_wr[c]  = r_cap_vld[c] && (!w_full[c] || w_pop[c]);
    end
  end

  always_ff @(posedge gclk) begin
    for (int c = 0; c < 2; c++)
      if (w_wr[c]) r_mem[c][r_wp[c]] <= {r_cap_dest[c], r_cap_atom[c], w_data_in[c]};
  end

  always_ff @(posedge gclk or negedge reset_l) begin
    if (!reset_l) begin
      for (int c = 0; c < 2; c++) begin
        r_cap_vld[c]  <= 1'b0;
        r_cap_dest[c] <= 5'd0;
        r_cap_atom[c] <= 1'b0;
        r_wp[c]       <= '0;
        r_rp[c]       <= '0;
        r_cnt[c]      <= '0;
        r_grant[c]    <= 5'd0;
      end
      r_rr        <= 1'b0;
      r_lock_vld  <= 1'b0;
      r_lock_core <= 1'b0;
      r_hold_vld  <= 1'b0;
      r_hold_core <= 1'b0;
      r_err_ovf   <= 2'b00;
      r_err_req   <= 2'b00;
    end else begin
      for (int c = 0; c < 2; c++) begin
        r_cap_vld[c]  <= (w_req[c] != 5'd0) && !multi_hot(w_req[c]);
        r_cap_dest[c] <= w_req[c];
        r_cap_atom[c] <= w_atom_in[c];
        if (multi_hot(w_req[c]))      r_err_req[c] <= 1'b1;
        if (r_cap_vld[c] && !w_wr[c]) r_err_ovf[c] <= 1'b1;
        if (w_wr[c])  r_wp[c] <= ptr_inc(r_wp[c]);
        if (w_pop[c]) r_rp[c] <= ptr_inc(r_rp[c]);
        r_cnt[c]   <= r_cnt[c] + (PTR_W+1)'(w_wr[c]) - (PTR_W+1)'(w_pop[c]);
        r_grant[c] <= w_pop[c] ? out_dest : 5'd0;
      end
      r_hold_vld  <= w_vld & ~out_rdy;
      r_hold_core <= w_sel;
      if (w_xfer) begin
        r_rr <= w_sel;
        if (r_lock_vld) begin
          r_lock_vld <= 1'b0;
        end else if (w_head[124]) begin
          r_lock_vld  <= 1'b1;
          r_lock_core <= w_sel;
        end
      end
    end
  end

  assign c0_pcx_grant_px = r_grant[0];
  assign c1_pcx_grant_px = r_grant[1];
  assign err_ovf         = r_err_ovf;
  assign err_req         = r_err_req;

endmodule

// File: tb/tb_pcx_fpga_arb.sv
// Bench for pcx_fpga_arb: directed scenarios plus random traffic, all checked
// each cycle against a queue-based model of the arbiter.
module tb_pcx_fpga_arb;

  logic         gclk = 1'b0;
  logic         reset_l = 1'b0;
  logic [4:0]   c0_req = '0, c1_req = '0;
  logic         c0_atom = 1'b0, c1_atom = 1'b0;
  logic [123:0] c0_data = '0, c1_data = '0;
  logic [4:0]   c0_grant, c1_grant;
  logic         out_vld, out_rdy = 1'b0;
  logic [123:0] out_data;
  logic [4:0]   out_dest;
  logic         out_core, out_atom;
  logic [1:0]   err_ovf, err_req;

  always #5 gclk = ~gclk;

  pcx_fpga_arb #(.DEPTH(10), .PTR_W(4)) dut (
    .gclk(gclk), .reset_l(reset_l),
    .c0_pcx_req_pq(c0_req), .c0_pcx_atom_pq(c0_atom), .c0_pcx_data_pa(c0_data),
    .c0_pcx_grant_px(c0_grant),
    .c1_pcx_req_pq(c1_req), .c1_pcx_atom_pq(c1_atom), .c1_pcx_data_pa(c1_data),
    .c1_pcx_grant_px(c1_grant),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_dest(out_dest),
    .out_core(out_core), .out_atom(out_atom), .err_ovf(err_ovf), .err_req(err_req)
  );

  int checks = 0;
  int errors = 0;

  // model state: per-core packet queues plus the arbitration facts
  logic [129:0] mq[2][$];
  bit           pv[2];
  logic [4:0]   pd[2];
  bit           pa[2];
  bit           m_rr, m_lk, m_lkc, m_hv, m_hc;
  logic [4:0]   m_g[2];
  logic [1:0]   m_ovf, m_req;

  // DUT values sampled in the latest cycle, and the log of transfers seen
  logic         s_vld, s_core;
  logic [123:0] s_data;
  logic [4:0]   s_g0, s_g1;
  logic [1:0]   s_ovf, s_ereq;
  logic [123:0] xlog[$];
  bit           xcore[$];

  task automatic chk(input string nm, input logic [129:0] act, input logic [129:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      mq[c].delete();
      pv[c] = 0; pd[c] = '0; pa[c] = 0; m_g[c] = '0;
    end
    m_rr = 0; m_lk = 0; m_lkc = 0; m_hv = 0; m_hc = 0;
    m_ovf = '0; m_req = '0;
  endtask

  task automatic cyc(input logic [4:0] r0, input logic a0, input logic [123:0] d0,
                     input logic [4:0] r1, input logic a1, input logic [123:0] d1,
                     input logic rdy);
    bit vld, sel;
    logic [129:0] hd;
    logic [4:0] r;
    @(negedge gclk);
    c0_req = r0; c0_atom = a0; c0_data = d0;
    c1_req = r1; c1_atom = a1; c1_data = d1;
    out_rdy = rdy;
    #1;
    s_vld = out_vld; s_core = out_core; s_data = out_data;
    s_g0 = c0_grant; s_g1 = c1_grant; s_ovf = err_ovf; s_ereq = err_req;
    if (!reset_l) begin
      chk("rst_vld", {129'b0, out_vld}, 130'd0);
      chk("rst_grants", {120'b0, c0_grant, c1_grant}, 130'd0);
      chk("rst_errs", {126'b0, err_ovf, err_req}, 130'd0);
      model_reset();
      return;
    end
    if (s_vld && rdy) begin
      xlog.push_back(s_data);
      xcore.push_back(s_core);
    end
    vld = 0; sel = 0;
    if (m_lk) begin
      sel = m_lkc; vld = mq[sel].size() != 0;
    end else if (m_hv) begin
      sel = m_hc; vld = 1;
    end else if (mq[0].size() != 0 && mq[1].size() != 0) begin
      sel = !m_rr; vld = 1;
    end else if (mq[0].size() != 0) begin
      sel = 0; vld = 1;
    end else if (mq[1].size() != 0) begin
      sel = 1; vld = 1;
    end
    chk("out_vld", {129'b0, out_vld}, {129'b0, vld});
    if (vld) begin
      hd = mq[sel][0];
      chk("out_data", {6'b0, out_data}, {6'b0, hd[123:0]});
      chk("out_dest", {125'b0, out_dest}, {125'b0, hd[129:125]});
      chk("out_core", {129'b0, out_core}, {129'b0, sel});
      chk("out_atom", {129'b0, out_atom}, {129'b0, hd[124]});
    end
    chk("grant0", {125'b0, c0_grant}, {125'b0, m_g[0]});
    chk("grant1", {125'b0, c1_grant}, {125'b0, m_g[1]});
    chk("err_ovf", {128'b0, err_ovf}, {128'b0, m_ovf});
    chk("err_req", {128'b0, err_req}, {128'b0, m_req});
    // advance the model across the coming rising edge
    m_g[0] = '0; m_g[1] = '0;
    if (vld && rdy) begin
      hd = mq[sel].pop_front();
      m_g[sel] = hd[129:125];
      m_rr = sel;
      if (m_lk) m_lk = 0;
      else if (hd[124]) begin m_lk = 1; m_lkc = sel; end
    end
    m_hv = vld && !rdy; m_hc = sel;
    for (int c = 0; c < 2; c++) begin
      if (pv[c]) begin
        if (mq[c].size() < 10) mq[c].push_back({pd[c], pa[c], (c == 0) ? d0 : d1});
        else m_ovf[c] = 1'b1;
      end
    end
    for (int c = 0; c < 2; c++) begin
      r = (c == 0) ? r0 : r1;
      pv[c] = 0;
      if (r != 0) begin
        if ($countones(r) > 1) m_req[c] = 1'b1;
        else begin pv[c] = 1; pd[c] = r; pa[c] = (c == 0) ? a0 : a1; end
      end
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(5'd0, 1'b0, '0, 5'd0, 1'b0, '0, rdy);
  endtask

  task automatic rst_pulse();
    reset_l = 1'b0;
    idle(2, 1'b1);
    reset_l = 1'b1;
    idle(2, 1'b1);
  endtask

  function automatic logic [4:0] rnd_req();
    int k;
    k = $urandom_range(0, 19);
    if (k < 10) return 5'd0;
    if (k < 19) return 5'd1 << $urandom_range(0, 4);
    return 5'b00011 << $urandom_range(0, 3);
  endfunction

  function automatic logic [123:0] rnd_data();
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    return t[123:0];
  endfunction

  initial begin
    int k;
    model_reset();
    idle(3, 1'b1);
    reset_l = 1'b1;
    idle(6, 1'b1);

    // single c0 packet: out at N+2, grant at N+3
    cyc(5'b00001, 1'b0, '0, 5'd0, 1'b0, '0, 1'b1);
    cyc(5'd0, 1'b0, 124'hA5, 5'd0, 1'b0, '0, 1'b1);
    cyc(5'd0, 1'b0, '0, 5'd0, 1'b0, '0, 1'b1);
    chk("t1_vld", {129'b0, s_vld}, 130'd1);
    chk("t1_data", {6'b0, s_data}, 130'hA5);
    chk("t1_core", {129'b0, s_core}, 130'd0);
    cyc(5'd0, 1'b0, '0, 5'd0, 1'b0, '0, 1'b1);
    chk("t1_grant0", {125'b0, s_g0}, 130'd1);
    chk("t1_grant1", {125'b0, s_g1}, 130'd0);

    // simultaneous requests after reset: c1 first
    rst_pulse();
    cyc(5'b00010, 1'b0, '0, 5'b00100, 1'b0, '0, 1'b1);
    cyc(5'd0, 1'b0, 124'd1, 5'd0, 1'b0, 124'd2, 1'b1);
    cyc(5'd0, 1'b0, '0, 5'd0, 1'b0, '0, 1'b1);
    chk("t2_first_core", {129'b0, s_core}, 130'd1);
    chk("t2_first_data", {6'b0, s_data}, 130'd2);
    cyc(5'd0, 1'b0, '0, 5'd0, 1'b0, '0, 1'b1);
    chk("t2_second_core", {129'b0, s_core}, 130'd0);
    chk("t2_second_data", {6'b0, s_data}, 130'd1);
    chk("t2_grant1", {125'b0, s_g1}, 130'b00100);
    cyc(5'd0, 1'b0, '0, 5'd0, 1'b0, '0, 1'b1);
    chk("t2_grant0", {125'b0, s_g0}, 130'b00010);

    // atomic pair on c0 against a c1 stream
    xlog.delete(); xcore.delete();
    cyc(5'b00001, 1'b1, '0, 5'b01000, 1'b0, '0, 1'b1);
    cyc(5'b00001, 1'b0, 124'hD1, 5'b01000, 1'b0, 124'hE1, 1'b1);
    cyc(5'd0, 1'b0, 124'hD2, 5'b01000, 1'b0, 124'hE2, 1'b1);
    for (int i = 0; i < 6; i++) cyc(5'd0, 1'b0, '0, 5'b01000, 1'b0, 124'hE3 + 124'(i), 1'b1);
    idle(8, 1'b1);
    k = -1;
    for (int i = 0; i < xlog.size(); i++) if (xlog[i] == 124'hD1 && xcore[i] == 1'b0) k = i;
    chk("t3_first_found", {129'b0, k >= 0}, 130'd1);
    if (k >= 0 && k + 1 < xlog.size())
      chk("t3_pair_adjacent", {6'b0, xlog[k+1]}, 130'hD2);
    else
      chk("t3_pair_present", 130'(k + 1), 130'(xlog.size() - 1));

    // overflow: eleven requests into a stalled queue
    xlog.delete(); xcore.delete();
    for (int j = 0; j < 12; j++)
      cyc((j < 11) ? 5'b00010 : 5'd0, 1'b0, (j > 0) ? 124'h100 + 124'(j - 1) : '0,
          5'd0, 1'b0, '0, 1'b0);
    idle(8, 1'b0);
    chk("t4_err_ovf", {128'b0, s_ovf}, 130'b01);
    idle(16, 1'b1);
    chk("t4_count", 130'(xlog.size()), 130'd10);
    for (int i = 0; i < 10 && i < xlog.size(); i++)
      chk("t4_order", {6'b0, xlog[i]}, 130'h100 + 130'(i));

    // multi-hot request dropped, next legal one passes
    xlog.delete(); xcore.delete();
    cyc(5'd0, 1'b0, '0, 5'b00011, 1'b0, '0, 1'b1);
    cyc(5'd0, 1'b0, '0, 5'b00100, 1'b0, 124'hBAD, 1'b1);
    cyc(5'd0, 1'b0, '0, 5'd0, 1'b0, 124'hC5, 1'b1);
    idle(4, 1'b1);
    chk("t5_err_req", {128'b0, s_ereq}, 130'b10);
    chk("t5_count", 130'(xlog.size()), 130'd1);
    if (xlog.size() > 0) chk("t5_data", {6'b0, xlog[0]}, 130'hC5);

    // asynchronous reset with both queues loaded
    for (int j = 0; j < 5; j++)
      cyc(5'b00001, 1'b0, 124'h200 + 124'(j), 5'b00010, 1'b0, 124'h300 + 124'(j), 1'b0);
    cyc(5'd0, 1'b0, 124'h205, 5'd0, 1'b0, 124'h305, 1'b1);
    #1 reset_l = 1'b0;
    #1;
    chk("t6_async_vld", {129'b0, out_vld}, 130'd0);
    chk("t6_async_grants", {120'b0, c0_grant, c1_grant}, 130'd0);
    chk("t6_async_errs", {126'b0, err_ovf, err_req}, 130'd0);
    model_reset();
    idle(2, 1'b1);
    reset_l = 1'b1;
    idle(10, 1'b1);

    // random traffic
    for (int i = 0; i < 4000; i++)
      cyc(rnd_req(), ($urandom_range(0, 4) == 0), rnd_data(),
          rnd_req(), ($urandom_range(0, 4) == 0), rnd_data(),
          ($urandom_range(0, 3) != 0));
    idle(40, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
